// File: rtl/uart_rx_buffer_pkg.sv
// Shared definitions for the UART receive buffer: Avalon register map,
// STATUS/CONTROL bit positions and the STATUS word packer.
package uart_rx_buffer_pkg;

    typedef enum logic [1:0] {
        REG_DATA    = 2'd0,
        REG_STATUS  = 2'd1,
        REG_CONTROL = 2'd2,
        REG_RSVD    = 2'd3
    } reg_addr_e;

    localparam int ST_EMPTY    = 0;
    localparam int ST_FULL     = 1;
    localparam int ST_OVERRUN  = 2;
    localparam int ST_IRQ_EN   = 3;
    localparam int ST_COUNT_LO = 8;

    localparam int CTRL_IRQ_EN = 0;

    typedef struct packed {
        logic [7:0] count;
        logic       irq_en;
        logic       overrun;
        logic       full;
        logic       empty;
    } status_t;

    function automatic logic [31:0] pack_status(input status_t s);
        logic [31:0] w;
        w = '0;
        w[ST_COUNT_LO +: 8] = s.count;
        w[ST_IRQ_EN]        = s.irq_en;
        w[ST_OVERRUN]       = s.overrun;
        w[ST_FULL]          = s.full;
        w[ST_EMPTY]         = s.empty;
        return w;
    endfunction

endpackage

// File: rtl/uart_rx_buffer_if.sv
// Byte-capture strobe from the receive core plus the Avalon-MM slave bus
// and the interrupt line, bundled for the receive buffer.
interface uart_rx_buffer_if;
    logic [7:0]  rx_data;
    logic        rx_done;
    logic [1:0]  avs_address;
    logic        avs_read;
    logic        avs_write;
    logic [31:0] avs_writedata;
    logic [31:0] avs_readdata;
    logic        irq;

    modport master (
        output rx_data, rx_done, avs_address, avs_read, avs_write, avs_writedata,
        input  avs_readdata, irq
    );

    modport slave (
        input  rx_data, rx_done, avs_address, avs_read, avs_write, avs_writedata,
        output avs_readdata, irq
    );
endinterface

// File: rtl/uart_rx_buffer_fifo_mem.sv
// DEPTH x 8 register array: synchronous write port, combinational read port.
// Storage is never reset; the pointers in the parent decide what is reachable.
module uart_fifo_mem #(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [7:0]        wdata_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output logic [7:0]        rdata_o
);

    logic [7:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/uart_rx_buffer.sv
// Receive-side byte FIFO with an Avalon-MM DATA/STATUS/CONTROL register view
// and a registered level interrupt.
module uart_rx_buffer
    import uart_rx_buffer_pkg::*;
#(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic                  rx_clk,
    input  logic                  reset,
    uart_rx_buffer_if.slave       bus
);

    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]   count_q,  count_d;
    logic              overrun_q, overrun_d;
    logic              irq_en_q,  irq_en_d;
    logic [31:0]       rdata_q,   rdata_d;
    logic              irq_q,     irq_d;

    logic       empty, full, push, pop;
    logic       rd_data, rd_status, rd_ctrl;
    logic       wr_status, wr_ctrl;
    logic       ovr_set, ovr_clr;
    logic [7:0] head_byte;
    status_t    status;
    logic       unused_wd;

    assign unused_wd = ^{bus.avs_writedata[31:3], bus.avs_writedata[1]};

    assign empty = (count_q == '0);
    assign full  = (count_q == (ADDR_W+1)'(DEPTH));

    assign rd_data   = bus.avs_read  && (bus.avs_address == REG_DATA);
    assign rd_status = bus.avs_read  && (bus.avs_address == REG_STATUS);
    assign rd_ctrl   = bus.avs_read  && (bus.avs_address == REG_CONTROL);
    assign wr_status = bus.avs_write && (bus.avs_address == REG_STATUS);
    assign wr_ctrl   = bus.avs_write && (bus.avs_address == REG_CONTROL);

    // A pop frees a slot in the same cycle, so a full FIFO still accepts.
    assign pop  = rd_data && !empty;
    assign push = bus.rx_done && (!full || pop);

    assign ovr_set = bus.rx_done && full && !pop;
    assign ovr_clr = wr_status && bus.avs_writedata[ST_OVERRUN];

    uart_fifo_mem #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_mem (
        .clk     (rx_clk),
        .we_i    (push),
        .waddr_i (wr_ptr_q),
        .wdata_i (bus.rx_data),
        .raddr_i (rd_ptr_q),
        .rdata_o (head_byte)
    );

    always_comb begin
        status         = '0;
        status.count   = 8'(count_q);
        status.irq_en  = irq_en_q;
        status.overrun = overrun_q;
        status.full    = full;
        status.empty   = empty;
    end

    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        overrun_d = overrun_q;
        irq_en_d  = irq_en_q;
        rdata_d   = rdata_q;

        if (push) wr_ptr_d = wr_ptr_q + ADDR_W'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + ADDR_W'(1);

        case ({push, pop})
            2'b10:   count_d = count_q + (ADDR_W+1)'(1);
            2'b01:   count_d = count_q - (ADDR_W+1)'(1);
            default: count_d = count_q;
        endcase

        // Clear first so a same-cycle overrun set takes priority.
        if (ovr_clr) overrun_d = 1'b0;
        if (ovr_set) overrun_d = 1'b1;

        if (wr_ctrl) irq_en_d = bus.avs_writedata[CTRL_IRQ_EN];

        if (bus.avs_read) begin
            rdata_d = '0;
            if (rd_data && !empty) rdata_d = {23'b0, 1'b1, head_byte};
            if (rd_status)         rdata_d = pack_status(status);
            if (rd_ctrl)           rdata_d = {31'b0, irq_en_q};
        end

        irq_d = irq_en_d && ((count_d != '0) || overrun_d);
    end

    always_ff @(posedge rx_clk) begin
        if (reset) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            overrun_q <= 1'b0;
            irq_en_q  <= 1'b0;
            rdata_q   <= '0;
            irq_q     <= 1'b0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            overrun_q <= overrun_d;
            irq_en_q  <= irq_en_d;
            rdata_q   <= rdata_d;
            irq_q     <= irq_d;
        end
    end

    assign bus.avs_readdata = rdata_q;
    assign bus.irq          = irq_q;

endmodule

// File: tb/tb_uart_rx_buffer.sv
// Directed and random stimulus for uart_rx_buffer, checked against a
// queue-based model of the FIFO and register view.
module tb_uart_rx_buffer;

    localparam int DEPTH = 16;

    logic rx_clk = 1'b0;
    logic reset  = 1'b1;

    uart_rx_buffer_if bus ();

    uart_rx_buffer #(.DEPTH(DEPTH), .ADDR_W(4)) dut (
        .rx_clk (rx_clk),
        .reset  (reset),
        .bus    (bus)
    );

    always #5 rx_clk = ~rx_clk;

    int n_chk  = 0;
    int n_fail = 0;

    logic [7:0]  q[$];
    bit          m_ovr = 0;
    bit          m_ien = 0;
    logic [31:0] exp_rd = '0;
    logic        exp_irq = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock of stimulus; the model is advanced with the same inputs and
    // both outputs are compared shortly after the edge.
    task automatic step(input bit rst, input bit done, input logic [7:0] d,
                        input bit rd, input bit wr, input logic [1:0] a,
                        input logic [31:0] wd, input string tag);
        bit popped;
        reset             = rst;
        bus.rx_done       = done;
        bus.rx_data       = d;
        bus.avs_read      = rd;
        bus.avs_write     = wr;
        bus.avs_address   = a;
        bus.avs_writedata = wd;

        if (rst) begin
            q.delete();
            m_ovr   = 0;
            m_ien   = 0;
            exp_rd  = '0;
        end else begin
            if (rd) begin
                case (a)
                    2'd0: exp_rd = (q.size() > 0) ? {23'b0, 1'b1, q[0]} : 32'h0;
                    2'd1: exp_rd = {16'b0, 8'(q.size()), 4'b0, m_ien, m_ovr,
                                    q.size() == DEPTH, q.size() == 0};
                    2'd2: exp_rd = {31'b0, m_ien};
                    default: exp_rd = 32'h0;
                endcase
            end
            popped = rd && (a == 2'd0) && (q.size() > 0);
            if (popped) void'(q.pop_front());
            if (wr && a == 2'd1 && wd[2]) m_ovr = 0;
            if (wr && a == 2'd2) m_ien = wd[0];
            if (done) begin
                if (q.size() < DEPTH) q.push_back(d);
                else                  m_ovr = 1;
            end
        end
        exp_irq = m_ien && (q.size() > 0 || m_ovr);

        @(posedge rx_clk);
        #1;
        chk({tag, ".readdata"}, bus.avs_readdata, exp_rd);
        chk({tag, ".irq"}, {31'b0, bus.irq}, {31'b0, exp_irq});
    endtask

    task automatic idle(input string tag);
        step(0, 0, 8'h00, 0, 0, 2'd0, 32'h0, tag);
    endtask

    task automatic push(input logic [7:0] d, input string tag);
        step(0, 1, d, 0, 0, 2'd0, 32'h0, tag);
    endtask

    task automatic rdreg(input logic [1:0] a, input string tag);
        step(0, 0, 8'h00, 1, 0, a, 32'h0, tag);
    endtask

    task automatic wrreg(input logic [1:0] a, input logic [31:0] wd, input string tag);
        step(0, 0, 8'h00, 0, 1, a, wd, tag);
    endtask

    initial begin
        bus.rx_done = 0; bus.rx_data = 0; bus.avs_read = 0; bus.avs_write = 0;
        bus.avs_address = 0; bus.avs_writedata = 0;

        step(1, 0, 8'h00, 0, 0, 2'd0, 32'h0, "reset0");
        step(1, 0, 8'h00, 0, 0, 2'd0, 32'h0, "reset1");
        chk("reset.readdata_const", bus.avs_readdata, 32'h0);
        rdreg(2'd1, "reset.status");
        chk("reset.status_const", bus.avs_readdata, 32'h1);

        // Two bytes in, two out in order.
        push(8'h55, "p55");
        push(8'hA3, "pA3");
        rdreg(2'd0, "rd1");
        chk("rd1_const", bus.avs_readdata, 32'h155);
        rdreg(2'd0, "rd2");
        chk("rd2_const", bus.avs_readdata, 32'h1A3);
        rdreg(2'd1, "st_empty");
        chk("st_empty_const", bus.avs_readdata, 32'h1);

        // Empty read returns invalid and leaves the FIFO alone.
        rdreg(2'd0, "rd_empty");
        chk("rd_empty_const", bus.avs_readdata, 32'h0);
        rdreg(2'd1, "st_after_empty_rd");

        // 17 bytes into a 16-deep FIFO.
        for (int i = 0; i < 17; i++) push(8'(8'h10 + i), "fill");
        rdreg(2'd1, "st_full");
        chk("st_full_const", bus.avs_readdata, 32'h1006);
        wrreg(2'd1, 32'h4, "clr_ovr");
        rdreg(2'd1, "st_full_clr");
        chk("st_full_clr_const", bus.avs_readdata, 32'h1002);

        // Full with simultaneous push and pop: no overrun, new byte goes last.
        step(0, 1, 8'hEE, 1, 0, 2'd0, 32'h0, "full_push_pop");
        chk("full_push_pop_const", bus.avs_readdata, 32'h110);
        rdreg(2'd1, "st_full_pp");
        chk("st_full_pp_const", bus.avs_readdata, 32'h1002);
        for (int i = 0; i < 16; i++) rdreg(2'd0, "drain");
        chk("drain_last_const", bus.avs_readdata, 32'h1EE);

        // Empty FIFO, push and DATA read together.
        step(0, 1, 8'h77, 1, 0, 2'd0, 32'h0, "empty_push_pop");
        chk("empty_push_pop_const", bus.avs_readdata, 32'h0);
        rdreg(2'd0, "rd77");
        chk("rd77_const", bus.avs_readdata, 32'h177);

        // Interrupt behaviour.
        wrreg(2'd2, 32'h1, "ien_on");
        rdreg(2'd2, "ctrl_rd");
        push(8'h42, "irq_push");
        rdreg(2'd0, "irq_pop");
        for (int i = 0; i < 17; i++) push(8'(i), "ovr_fill");
        for (int i = 0; i < 16; i++) rdreg(2'd0, "ovr_drain");
        idle("ovr_hold");
        wrreg(2'd1, 32'hFFFF_FFFB, "no_clr");
        wrreg(2'd1, 32'h4, "clr");
        // Clear and overrun set on the same cycle: set wins.
        for (int i = 0; i < 16; i++) push(8'(i), "refill");
        step(0, 1, 8'h99, 0, 1, 2'd1, 32'h4, "set_wins");
        rdreg(2'd1, "st_set_wins");
        rdreg(2'd3, "rsvd_rd");
        wrreg(2'd0, 32'h1FF, "data_wr_ignored");
        rdreg(2'd1, "st_after_data_wr");

        // Reset with bytes queued.
        wrreg(2'd1, 32'h4, "clr2");
        for (int i = 0; i < 11; i++) rdreg(2'd0, "to5");
        step(1, 0, 8'h00, 0, 0, 2'd0, 32'h0, "mid_reset");
        chk("mid_reset.irq_const", {31'b0, bus.irq}, 32'h0);
        rdreg(2'd1, "st_post_reset");
        chk("st_post_reset_const", bus.avs_readdata, 32'h1);

        // Random traffic.
        for (int i = 0; i < 1500; i++) begin
            bit rst, done, rd, wr;
            logic [1:0] a;
            logic [31:0] wd;
            rst  = ($urandom_range(0, 199) == 0);
            done = ($urandom_range(0, 99) < 55);
            rd   = ($urandom_range(0, 99) < 45);
            wr   = ($urandom_range(0, 99) < 10);
            a    = ($urandom_range(0, 99) < 70) ? 2'd0 : 2'($urandom_range(0, 3));
            wd   = $urandom;
            step(rst, done, 8'($urandom), rd, wr, a, wd, "rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
